// File: rtl/zx_video_tx.sv
// ZX81-style mono video transmitter: PAL-like line/frame timing, composite sync,
// and a 1-bit pixel serializer fed from bytes fetched over a req/ack handshake.
module zx_video_tx #(
    parameter int LINE_LEN    = 414,
    parameter int HSYNC_START = 384,
    parameter int HSYNC_LEN   = 30,
    parameter int LINES       = 312,
    parameter int VSYNC_START = 248,
    parameter int VSYNC_LINES = 4,
    parameter int H_ACT_START = 32,
    parameter int V_ACT_START = 56
) (
    input  logic        clkvideo,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        invert,
    output logic        data_req,
    output logic [12:0] data_addr,
    input  logic        data_ack,
    input  logic [7:0]  data_in,
    output logic        csync,
    output logic        v_out,
    output logic        vblank,
    output logic        underrun
);

    localparam int HW = $clog2(LINE_LEN + 1);
    localparam int VW = $clog2(LINES + 1);

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] HS_LO  = HW'(HSYNC_START);
    localparam logic [HW-1:0] HS_HI  = HW'(HSYNC_START + HSYNC_LEN);
    localparam logic [HW-1:0] HA_LO  = HW'(H_ACT_START);
    localparam logic [HW-1:0] HA_HI  = HW'(H_ACT_START + 256);
    localparam logic [HW-1:0] HF_LO  = HW'(H_ACT_START - 8);
    localparam logic [HW-1:0] HF_HI  = HW'(H_ACT_START + 248);

    localparam logic [VW-1:0] V_LAST = VW'(LINES - 1);
    localparam logic [VW-1:0] VS_LO  = VW'(VSYNC_START);
    localparam logic [VW-1:0] VS_HI  = VW'(VSYNC_START + VSYNC_LINES);
    localparam logic [VW-1:0] VA_LO  = VW'(V_ACT_START);
    localparam logic [VW-1:0] VA_HI  = VW'(V_ACT_START + 192);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_req;
    logic [12:0]   r_addr;
    logic          r_full;
    logic [7:0]    r_latch;
    logic [7:0]    r_shift_p0;
    logic          r_underrun;
    logic          r_csync_p1;
    logic          r_vout_p1;
    logic          r_vblank_p1;

    logic          w_hsync;
    logic          w_vsync;
    logic          w_sync_n;
    logic          w_vact;
    logic          w_hact;
    logic          w_active;
    logic [2:0]    w_hphase;
    logic [4:0]    w_col;
    logic [7:0]    w_row;
    logic          w_load_pt;
    logic          w_fetch_pt;
    logic [2:0]    w_fphase;
    logic [4:0]    w_fetch_col;
    logic          w_ack;
    logic          w_have;
    logic [7:0]    w_load_byte;
    logic [7:0]    w_shift_next;

    assign w_hsync  = (r_h >= HS_LO) && (r_h < HS_HI);
    assign w_vsync  = (r_v >= VS_LO) && (r_v < VS_HI);
    assign w_sync_n = !(w_hsync || w_vsync);

    assign w_vact   = (r_v >= VA_LO) && (r_v < VA_HI);
    assign w_hact   = (r_h >= HA_LO) && (r_h < HA_HI);
    assign w_active = w_vact && w_hact;

    assign w_hphase = 3'(r_h - HA_LO);
    assign w_col    = 5'((r_h - HA_LO) >> 3);
    assign w_row    = 8'(r_v - VA_LO);

    // Fetch points lead the load points by one byte time, so each request has
    // eight pixels to be answered before its byte is due in the shifter.
    assign w_fphase    = 3'(r_h - HF_LO);
    assign w_fetch_col = 5'((r_h - HF_LO) >> 3);
    assign w_fetch_pt  = w_vact && (r_h >= HF_LO) && (r_h < HF_HI) && (w_fphase == 3'd0);
    assign w_load_pt   = w_active && (w_hphase == 3'd0);

    assign w_ack       = r_req && data_ack;
    assign w_have      = r_full || w_ack;
    assign w_load_byte = r_full ? r_latch : data_in;

    always_comb begin
        w_shift_next = r_shift_p0;
        if (w_load_pt) begin
            w_shift_next = w_have ? w_load_byte : 8'h00;
        end else if (w_active) begin
            w_shift_next = {r_shift_p0[6:0], 1'b0};
        end
    end

    // Stage p0: counters, handshake, byte latch and shifter
    always_ff @(posedge clkvideo) begin
        if (reset) begin
            r_h         <= '0;
            r_v         <= '0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_shift_p0  <= 8'h00;
            r_underrun  <= 1'b0;
            r_csync_p1  <= 1'b1;
            r_vout_p1   <= 1'b0;
            r_vblank_p1 <= 1'b1;
        end else begin
            if (w_ack) begin
                r_full <= 1'b1;
                r_req  <= 1'b0;
            end
            if (ce_pix) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end

                r_shift_p0 <= w_shift_next;

                // A load point consumes the latch (or a same-clock ack) and
                // retires whatever request was still pending for this column.
                if (w_load_pt) begin
                    r_full <= 1'b0;
                    r_req  <= 1'b0;
                    if (!w_have) begin
                        r_underrun <= 1'b1;
                    end
                end
                if (w_fetch_pt) begin
                    r_req  <= 1'b1;
                    r_addr <= {w_row, w_fetch_col};
                end

                // Stage p1: outputs, one pixel behind the counters
                r_csync_p1  <= w_sync_n;
                r_vblank_p1 <= !w_vact;
                r_vout_p1   <= w_active && (w_shift_next[7] ^ invert);
            end
        end
    end

    always_ff @(posedge clkvideo) begin
        if (w_ack) begin
            r_latch <= data_in;
        end
    end

    assign data_req  = r_req;
    assign data_addr = r_addr;
    assign csync     = r_csync_p1;
    assign v_out     = r_vout_p1;
    assign vblank    = r_vblank_p1;
    assign underrun  = r_underrun;

endmodule

// File: doc/zx_video_tx.md
Name: zx_video_tx

Overview:
- Transmit end of the ZX81-style mono video link consumed by the scandoubler.
- Generates PAL-like line/frame timing at pixel rate, a composite sync (low = sync), and a serialized 1-bit video stream fed from bytes fetched over a req/ack handshake.
- Sits between the video fetch logic (character/pattern lookup) and the scandoubler / composite output pins.

Parameters:
- LINE_LEN, 414: pixel enables per line (64 us at 6.5 MHz).
- HSYNC_START, 384: h_cnt at which the line sync pulse starts.
- HSYNC_LEN, 30: line sync width in pixels; must stay below 90 so the scandoubler reads it as hsync.
- LINES, 312: lines per frame.
- VSYNC_START, 248: first line of the vertical sync.
- VSYNC_LINES, 4: number of lines held fully low for vsync (>90 pixels, so the scandoubler detects vsync).
- H_ACT_START, 32: first active pixel column; active width is fixed at 256 (32 bytes).
- V_ACT_START, 56: first active line; active height is fixed at 192.

Ports:
- clkvideo, in, 1: single clock for the block.
- reset, in, 1: synchronous, active-high.
- ce_pix, in, 1: pixel clock enable; all timing advances only when high.
- invert, in, 1: when high, the video level is inverted inside the active area only.
- data_req, out, 1: byte request to the fetch logic.
- data_addr, out, 13: {row[7:0], col[4:0]} of the requested byte.
- data_ack, in, 1: fetch logic presents data_in in this clock cycle.
- data_in, in, 8: pixel byte, bit 7 shown first.
- csync, out, 1: composite sync, low = sync.
- v_out, out, 1: serialized video.
- vblank, out, 1: high outside the active lines.
- underrun, out, 1: sticky error flag; cleared only by reset.

Behaviour:
Reset:
- Reset has priority over everything, including mid-line and mid-request.
- Values after reset: h_cnt=0, v_cnt=0, csync=1, v_out=0, vblank=1, data_req=0, data_addr=0, underrun=0, shift register=0, byte latch empty.

Counters:
- h_cnt runs 0..LINE_LEN-1; v_cnt runs 0..LINES-1.
- Both advance only on ce_pix. h_cnt wraps to 0 and increments v_cnt; v_cnt wraps to 0 at the end of line LINES-1.

Sync:
- Combinational sync_n is low when h_cnt is in [HSYNC_START, HSYNC_START+HSYNC_LEN) or v_cnt is in [VSYNC_START, VSYNC_START+VSYNC_LINES).
- csync is sync_n registered on ce_pix (one pixel of latency).
- The vsync low run is therefore continuous: VSYNC_LINES*LINE_LEN pixels.

Active window:
- Active when v_cnt is in [V_ACT_START, V_ACT_START+192) and h_cnt is in [H_ACT_START, H_ACT_START+256).
- row = v_cnt - V_ACT_START (8 bits); col = (h_cnt - H_ACT_START) >> 3.
- vblank is registered on ce_pix and is low only during active lines.

Fetch handshake:
- On active lines, at the ce_pix where h_cnt == H_ACT_START - 8 + 8k (k = 0..31), set data_req=1 and data_addr={row, k}.
- data_req stays high until a clock with data_ack=1; that clock latches data_in, marks the latch full and drops data_req.
- data_ack while data_req=0 is ignored.

Shift register:
- At the ce_pix where h_cnt == H_ACT_START + 8k: if the latch is full (including an ack in the same clock, which bypasses into the shifter), load the byte and empty the latch. Otherwise load 0x00, set underrun=1 and drop any outstanding data_req.
- On every other active ce_pix, shift left one bit.
- The registered v_out = (shift[7] ^ invert) during active pixels, 0 otherwise.
- Total latency from pixel position to v_out is one ce_pix, aligned with csync.

Sync timing:
- HSYNC_START must be at least H_ACT_START+256; no requests are issued on inactive lines or while in sync.

Test Plan:
- Reset, then run 2 frames -> csync low for exactly 30 pixels per line starting at h_cnt 384 (line sync); on lines 248..251, csync low continuously for 1656 pixels; frame period is 129168 ce_pix.
- Always-ack the same cycle, data_in = {row, col} pattern -> on line 56, col 0, data_addr = 0x0000; at col 31, data_addr = 0x001F; v_out bits match MSB-first; underrun stays 0.
- data_in = 0xA5, invert=1 -> v_out = 0,1,0,1,1,0,1,0 in active pixels and 0 in the borders.
- Withhold ack for column 5 of row 10 -> those 8 pixels output 0 (invert=0), underrun=1 and sticky, data_req drops at the load point, column 6 fetch proceeds normally.
- Ack arriving on the same clock as the load ce_pix -> byte is displayed with no underrun.
- Assert reset mid-line at h_cnt=200, v_cnt=100 with data_req high -> next clock data_req=0, csync=1, v_out=0, and counters restart at 0,0.
